// File: rtl/fifo_param_if.sv
// Handshake/data bundle between a producer/consumer and fifo_param.
// The master modport is the user side; the slave modport is the FIFO itself.
interface fifo_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] data_in;
  logic             clear_err;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr, rd, data_in, clear_err,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr, rd, data_in, clear_err,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// Synchronous first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_param #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 8,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic        clock,
  input  logic        reset,
  fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full_w, empty_w;
  logic [PW-1:0]    count_w;
  logic             wr_accept, rd_accept;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count_w = wr_ptr_q - rd_ptr_q;

  // A read in the same cycle frees a slot, so a full FIFO still accepts wr&rd.
  assign rd_accept = bus.rd && !empty_w;
  assign wr_accept = bus.wr && (!full_w || bus.rd);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q && !bus.clear_err;
    underflow_d = underflow_q && !bus.clear_err;

    if (wr_accept) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_accept) rd_ptr_d = rd_ptr_q + PW'(1);

    // New error events override a same-cycle clear.
    if (bus.wr && full_w && !bus.rd) overflow_d  = 1'b1;
    if (bus.rd && empty_w)           underflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (!reset && wr_accept) mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;
  end

  assign bus.data_out     = empty_w ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.count        = count_w;
  assign bus.almost_full  = (count_w >= AFULL_C);
  assign bus.almost_empty = (count_w <= AEMPTY_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_param.sv
// Directed plus randomized bench for fifo_param, checked against a queue-based
// reference model of the FIFO's occupancy, ordering and sticky error rules.
module tb_fifo_param;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 1;
  localparam int AE    = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] mq[$];
  logic             m_of = 1'b0;
  logic             m_uf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_head();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".count"},        64'(bus.count),        64'(mq.size()));
    check({tag, ".empty"},        64'(bus.empty),        64'(mq.size() == 0));
    check({tag, ".full"},         64'(bus.full),         64'(mq.size() == DEPTH));
    check({tag, ".almost_full"},  64'(bus.almost_full),  64'(mq.size() >= AF));
    check({tag, ".almost_empty"}, 64'(bus.almost_empty), 64'(mq.size() <= AE));
    check({tag, ".overflow"},     64'(bus.overflow),     64'(m_of));
    check({tag, ".underflow"},    64'(bus.underflow),    64'(m_uf));
    check({tag, ".data_out"},     64'(bus.data_out),     64'(m_head()));
  endtask

  // One clock: drive inputs, clock the DUT, advance the model, compare everything.
  task automatic step(input string tag, input logic w, input logic r,
                      input logic [WIDTH-1:0] d, input logic clr, input logic rst);
    bit m_full, m_empty;
    reset         = rst;
    bus.wr        = w;
    bus.rd        = r;
    bus.data_in   = d;
    bus.clear_err = clr;
    @(posedge clock);
    #1;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    if (rst) begin
      mq.delete();
      m_of = 1'b0;
      m_uf = 1'b0;
    end else begin
      m_of = (w && m_full && !r) || (m_of && !clr);
      m_uf = (r && m_empty) || (m_uf && !clr);
      if (r && !m_empty)         void'(mq.pop_front());
      if (w && (!m_full || r))   mq.push_back(d);
    end
    check_all(tag);
  endtask

  initial begin
    bus.wr = 1'b0; bus.rd = 1'b0; bus.data_in = '0; bus.clear_err = 1'b0;

    // Reset then idle
    step("reset", 1'b0, 1'b0, '0, 1'b0, 1'b1);
    step("idle",  1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("idle.data_out_zero", 64'(bus.data_out), 64'h0);

    // Fill with 0x11..0x88
    for (int i = 1; i <= DEPTH; i++) begin
      step("fill", 1'b1, 1'b0, WIDTH'(32'h11 * i), 1'b0, 1'b0);
      if (i == AF) check("fill.af_at_7", 64'(bus.almost_full), 64'h1);
    end
    check("fill.full", 64'(bus.full), 64'h1);
    check("fill.count8", 64'(bus.count), 64'd8);

    // Drain: data_out before each popping edge is the expected word
    for (int i = 1; i <= DEPTH; i++) begin
      check("drain.head", 64'(bus.data_out), 64'(32'h11 * i));
      step("drain", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    end
    check("drain.empty", 64'(bus.empty), 64'h1);

    // Full boundary: dropped write, then simultaneous wr/rd at full
    for (int i = 1; i <= DEPTH; i++) step("refill", 1'b1, 1'b0, WIDTH'(32'hA0 + i), 1'b0, 1'b0);
    step("drop", 1'b1, 1'b0, WIDTH'(32'hDEAD), 1'b0, 1'b0);
    check("drop.overflow", 64'(bus.overflow), 64'h1);
    check("drop.count", 64'(bus.count), 64'd8);
    step("full_wr_rd", 1'b1, 1'b1, WIDTH'(32'hBEEF), 1'b0, 1'b0);
    check("full_wr_rd.count", 64'(bus.count), 64'd8);
    check("full_wr_rd.head", 64'(bus.data_out), 64'hA2);
    for (int i = 1; i <= DEPTH; i++) begin
      if (i == DEPTH) check("beef_last", 64'(bus.data_out), 64'hBEEF);
      step("drain2", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    end

    // Empty boundary
    step("ignored_rd", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    check("ignored_rd.underflow", 64'(bus.underflow), 64'h1);
    step("empty_wr_rd", 1'b1, 1'b1, WIDTH'(32'h5A5A), 1'b0, 1'b0);
    check("empty_wr_rd.count", 64'(bus.count), 64'd1);
    check("empty_wr_rd.data", 64'(bus.data_out), 64'h5A5A);
    check("empty_wr_rd.uf_held", 64'(bus.underflow), 64'h1);
    step("pop_5a5a", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    step("clr_vs_uf", 1'b0, 1'b1, '0, 1'b1, 1'b0);
    check("clr_vs_uf.set_wins", 64'(bus.underflow), 64'h1);
    step("clr", 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("clr.underflow", 64'(bus.underflow), 64'h0);
    check("clr.overflow", 64'(bus.overflow), 64'h0);

    // Wrap-around: random traffic at occupancy 3..5
    for (int i = 0; i < 4; i++) step("pre_wrap", 1'b1, 1'b0, WIDTH'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3 * DEPTH + 3; i++) begin
      logic w, r;
      w = 1'($urandom);
      r = 1'($urandom);
      if (mq.size() <= 3) w = 1'b1;
      if (mq.size() >= 5) r = 1'b1;
      if (mq.size() <= 3 && r) r = 1'($urandom);
      step("wrap", w, r, WIDTH'($urandom), 1'b0, 1'b0);
    end

    // Mid-operation reset with count=5 and overflow set
    while (mq.size() < DEPTH) step("to_full", 1'b1, 1'b0, WIDTH'($urandom), 1'b0, 1'b0);
    step("set_of", 1'b1, 1'b0, WIDTH'(32'h1234), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("to5", 1'b0, 1'b1, '0, 1'b0, 1'b0);
    check("pre_rst.count5", 64'(bus.count), 64'd5);
    check("pre_rst.of", 64'(bus.overflow), 64'h1);
    step("mid_reset", 1'b1, 1'b0, WIDTH'(32'hCAFE), 1'b0, 1'b1);
    check("mid_reset.count", 64'(bus.count), 64'd0);
    check("mid_reset.empty", 64'(bus.empty), 64'h1);
    check("mid_reset.overflow", 64'(bus.overflow), 64'h0);
    step("post_reset", 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("post_reset.discarded", 64'(bus.data_out), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
